// File: rtl/ulaplus_palette_ctrl.sv
// rtl/ulaplus_palette_ctrl.sv - ULAplus palette LUT CPU-side controller (I/O decode, write sequencing, init sweep)
//
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   cpu_a, iorq_n,      Z80 address bus and active-low I/O strobes
//   wr_n, rd_n
//   cpu_din / cpu_dout  Z80 write data / readback data, oe high when cpu_dout drives the bus
//   lut_a3, lut_din,    LUT CPU-side port: address, write data, one-cycle write enable,
//   lut_load, lut_do3   and read data at lut_a3
//   ulaplus_enabled     mode register bit 0
//   busy                high while the post-reset clear sweep runs
//
// Build option: define ULAPLUS_AUTOINC_EN to advance the palette index after every
// group-00 data port write (index wraps 63 -> 0).
module ulaplus_palette_ctrl #(
    parameter logic [15:0] REG_PORT   = 16'hBF3B,
    parameter logic [15:0] DATA_PORT  = 16'hFF3B,
    parameter logic [7:0]  INIT_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_a,
    input  logic        iorq_n,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        oe,
    output logic [5:0]  lut_a3,
    output logic [7:0]  lut_din,
    output logic        lut_load,
    input  logic [7:0]  lut_do3,
    output logic        ulaplus_enabled,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE
    } state_t;

    localparam logic [6:0] SWEEP_LEN = 7'd64;

    state_t      state, state_nxt;
    logic [6:0]  cnt, cnt_nxt;

    logic        iow, ior, iow_q;
    logic        wr_evt, reg_wr, data_wr;

    logic [1:0]  grp, grp_nxt;
    logic [5:0]  idx, idx_nxt;
    logic        mode, mode_nxt;

    logic        pend, pend_nxt;
    logic [5:0]  pidx, pidx_nxt;
    logic [7:0]  pdat, pdat_nxt;

    logic        load_nxt;
    logic [5:0]  a3_nxt;
    logic [7:0]  din_nxt;
    logic        busy_nxt;

    assign iow     = ~iorq_n & ~wr_n;
    assign ior     = ~iorq_n & ~rd_n;
    // Only the first cycle of a write strobe acts, so a multi-cycle OUT is one event.
    assign wr_evt  = iow & ~iow_q;
    assign reg_wr  = wr_evt & (cpu_a == REG_PORT);
    assign data_wr = wr_evt & (cpu_a == DATA_PORT);

    assign oe              = ior & (cpu_a == DATA_PORT);
    assign ulaplus_enabled = mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            cnt      <= 7'd0;
            iow_q    <= 1'b0;
            grp      <= 2'b00;
            idx      <= 6'd0;
            mode     <= 1'b0;
            pend     <= 1'b0;
            pidx     <= 6'd0;
            pdat     <= 8'h00;
            lut_load <= 1'b0;
            lut_a3   <= 6'd0;
            lut_din  <= 8'h00;
            busy     <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            iow_q    <= iow;
            grp      <= grp_nxt;
            idx      <= idx_nxt;
            mode     <= mode_nxt;
            pend     <= pend_nxt;
            pidx     <= pidx_nxt;
            pdat     <= pdat_nxt;
            lut_load <= load_nxt;
            lut_a3   <= a3_nxt;
            lut_din  <= din_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grp_nxt   = grp;
        idx_nxt   = idx;
        mode_nxt  = mode;
        pend_nxt  = pend;
        pidx_nxt  = pidx;
        pdat_nxt  = pdat;
        load_nxt  = 1'b0;
        din_nxt   = lut_din;
        busy_nxt  = 1'b0;

        if (reg_wr) begin
            grp_nxt = cpu_din[7:6];
            idx_nxt = cpu_din[5:0];
        end

        if (data_wr) begin
            case (grp)
                2'b00: begin
                    // The target index is frozen here; later register writes cannot redirect it.
                    pidx_nxt = idx;
                    pdat_nxt = cpu_din;
`ifdef ULAPLUS_AUTOINC_EN
                    idx_nxt  = idx + 6'd1;
`endif
                end
                2'b01:   mode_nxt = cpu_din[0];
                default: ;
            endcase
        end

        // Outside the sweep and the commit cycle the LUT address follows the index,
        // so group-00 readback is a plain combinational path through lut_do3.
        a3_nxt = idx_nxt;

        case (state)
            ST_INIT: begin
                busy_nxt = 1'b1;
                if (cnt == SWEEP_LEN) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    load_nxt = 1'b1;
                    a3_nxt   = cnt[5:0];
                    din_nxt  = INIT_VALUE;
                    cnt_nxt  = cnt + 7'd1;
                end
            end
            ST_IDLE: begin
                if (pend) begin
                    state_nxt = ST_WRITE;
                    load_nxt  = 1'b1;
                    a3_nxt    = pidx;
                    din_nxt   = pdat;
                    pend_nxt  = 1'b0;
                end
            end
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_INIT;
                cnt_nxt   = 7'd0;
            end
        endcase

        // A new capture outranks the clear above: its data is not the one being committed.
        if (data_wr && grp == 2'b00) begin
            pend_nxt = 1'b1;
        end
    end

    always_comb begin
        cpu_dout = 8'hFF;
        if (state == ST_INIT) begin
            cpu_dout = INIT_VALUE;
        end else if (grp == 2'b00) begin
            cpu_dout = lut_do3;
        end else if (grp == 2'b01) begin
            cpu_dout = {7'b0, mode};
        end
    end

endmodule

// File: doc/ulaplus_palette_ctrl.md
Name: ulaplus_palette_ctrl

Overview:
Controller for the 64x8 ULAplus palette LUT. It decodes Z80 I/O accesses to the ULAplus register and data ports and owns the LUT's CPU-side address/write port (a3, din, load). It sequences palette writes, provides palette/mode readback, and runs a post-reset clear sweep of all 64 entries. The video ports (a1, a2) stay with the video pipeline and are untouched by this block.

Parameters:
REG_PORT, 16'hBF3B, full 16-bit I/O address of the register (select) port
DATA_PORT, 16'hFF3B, full 16-bit I/O address of the data port
INIT_VALUE, 8'h00, value written to every entry during the reset sweep

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
cpu_a  in  16  Z80 address bus
iorq_n  in  1  Z80 IORQ, active low
wr_n  in  1  Z80 WR, active low
rd_n  in  1  Z80 RD, active low
cpu_din  in  8  Z80 data bus, write data
cpu_dout  out  8  readback data
oe  out  1  high when cpu_dout must drive the bus
lut_a3  out  6  LUT write/readback address
lut_din  out  8  LUT write data
lut_load  out  1  LUT write enable, one cycle per write
lut_do3  in  8  LUT data at lut_a3
ulaplus_enabled  out  1  mode register bit 0
busy  out  1  high during the init sweep

Behaviour:
- Reset (rst_n low, async): state=INIT, sweep count=0, lut_load=0, lut_a3=0, lut_din=0, group=00, index=0, mode=0, pending=0, busy=1.
- Strobes: iow = !iorq_n & !wr_n; ior = !iorq_n & !rd_n. The write strobe is registered once. A write event is the cycle where the strobe is high and its registered copy is low (rising edge), so each I/O write acts exactly once.
- Register port write event: group <= cpu_din[7:6], index <= cpu_din[5:0], visible next cycle.
- Data port write event:
  - group 00: capture {index, cpu_din} into the pending slot; pending=1.
  - group 01: mode <= cpu_din[0].
  - groups 10/11: ignored.
- States: INIT, IDLE, WRITE.
  - INIT: lut_load=1, lut_din=INIT_VALUE, lut_a3 = count 0..63, one entry per cycle, starting the first edge after rst_n deasserts.
  - INIT lasts 64 cycles. lut_load and busy drop on the same edge that enters IDLE.
  - IDLE: when pending=1, go to WRITE.
  - WRITE: drive lut_a3 = captured index and lut_din = captured data; lut_load=1 for exactly one cycle; clear pending; return to IDLE.
  - Latency: lut_load is high in the second cycle after the write-event cycle. Entry readable via lut_do3 on the following cycle.
- IDLE/WRITE addressing: lut_a3 = index when not writing, giving combinational readback through lut_do3.
- Reads: oe = ior & (cpu_a==DATA_PORT), combinational.
  - group 00: cpu_dout = lut_do3.
  - group 01: cpu_dout = {7'b0, mode}.
  - otherwise: cpu_dout = 8'hFF.
  - During INIT: cpu_dout = INIT_VALUE.
  - The register port is write-only: oe=0.
- Boundaries:
  - A write event arriving while pending=1 overwrites the pending slot; the last value wins. Write events are at least 2 cycles apart, so IDLE writes never collide.
  - A register port write after a data write but before commit does not redirect that write; the index was captured with the data.
  - Data port writes during INIT are held pending (last wins) and committed right after INIT.
  - rst_n asserted mid-sweep or mid-write restarts INIT from 0.
- ulaplus_enabled = mode, registered.

Optional Feature:
ULAPLUS_AUTOINC_EN
- Defined: each group-00 data port write event increments index modulo 64 (63 wraps to 0) in the cycle after the event; group is unchanged. The pending write still uses the pre-increment index.
- Undefined: index changes only on register port writes.

Test Plan:
- Release reset -> lut_load high 64 consecutive cycles, lut_a3 0..63, lut_din=8'h00, busy falls with lut_load; no load afterwards.
- After INIT: OUT BF3B,8'h05; OUT FF3B,8'hA7 -> lut_load high exactly one cycle 2 cycles after the edge, lut_a3=5, lut_din=A7; IN FF3B returns 8'hA7 with oe=1.
- OUT BF3B,8'h40; OUT FF3B,8'h01 -> ulaplus_enabled=1, no lut_load; IN FF3B returns 8'h01; IN BF3B gives oe=0.
- OUT BF3B,8'h3F then an FF3B write during INIT cycle 10 with 8'h11 -> committed to entry 63 right after INIT; a second write during INIT with 8'h22 gives entry 63 = 8'h22 and only one post-INIT load.
- With ULAPLUS_AUTOINC_EN: index=63, writes 8'h01, 8'h02 -> entries 63 and 0 loaded. Without the macro: both writes go to entry 63.
- Assert rst_n mid-sweep at count 30 -> outputs return to reset values immediately; the sweep restarts at 0 and runs a full 64 cycles.
